// File: rtl/rotator_sequencer_pkg.sv
// rtl/rotator_sequencer_pkg.sv - shared state encoding and default sizes for rotator_sequencer
package rotator_sequencer_pkg;

    localparam int STATE_W      = 2;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_STEP_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rotator_sequencer_step_counter.sv
// rtl/rotator_sequencer_step_counter.sv - loadable down-counter of remaining shift steps
module rotator_sequencer_step_counter #(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [STEP_W-1:0] load_val,
    input  logic              dec,
    output logic [STEP_W-1:0] count,
    output logic              last,
    output logic              zero
);

    // Load takes priority; decrement stops at zero so a stray dec cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // last marks the final shift cycle; zero means no shifting is needed at all.
    always_comb begin
        last = (count == {{(STEP_W-1){1'b0}}, 1'b1});
        zero = (count == '0);
    end

endmodule

// File: rtl/rotator_sequencer.sv
// rtl/rotator_sequencer.sv - turns one command into an exact load/shift/done cycle sequence
module rotator_sequencer
    import rotator_sequencer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic              cmd_load,
    input  logic              cmd_right,
    input  logic              cmd_asr,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [WIDTH-1:0]  sr_q,
    output logic              sr_shift,
    output logic              sr_right,
    output logic              sr_asr,
    output logic [WIDTH-1:0]  sr_data,
    output logic              done
);

    seq_state_e       state, state_nxt;
    logic             accept;
    logic             cnt_dec;
    logic             cnt_last;
    logic             cnt_zero;
    logic [STEP_W-1:0] cnt_val;
    logic [WIDTH-1:0] lat_data;
    logic             lat_right;
    logic             lat_asr;

    assign accept = (state == ST_IDLE) && start;

    rotator_sequencer_step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cmd_steps),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the command on acceptance so later cmd_* changes cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_data  <= '0;
            lat_right <= 1'b0;
            lat_asr   <= 1'b0;
        end else if (accept) begin
            lat_data  <= cmd_data;
            lat_right <= cmd_right;
            lat_asr   <= cmd_asr;
        end
    end

    // Next state and Moore output decode; idle/done reload sr_q so the register holds.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        sr_shift  = 1'b0;
        sr_right  = 1'b0;
        sr_asr    = 1'b0;
        sr_data   = sr_q;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (cmd_load) begin
                        state_nxt = ST_LOAD;
                    end else if (cmd_steps != '0) begin
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                sr_data   = lat_data;
                state_nxt = cnt_zero ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_shift = 1'b1;
                sr_right = lat_right;
                sr_asr   = lat_asr & lat_right;
                cnt_dec  = 1'b1;
                if (cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rotator_sequencer.sv
// tb/tb_rotator_sequencer.sv - self-checking bench for rotator_sequencer with a register model
module tb_rotator_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready;
    logic       cmd_load = 1'b0;
    logic       cmd_right = 1'b0;
    logic       cmd_asr = 1'b0;
    logic [3:0] cmd_steps = 4'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] sr_q = 8'h00;
    logic       sr_shift;
    logic       sr_right;
    logic       sr_asr;
    logic [7:0] sr_data;
    logic       done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rotator_sequencer #(.WIDTH(8), .STEP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .cmd_load  (cmd_load),
        .cmd_right (cmd_right),
        .cmd_asr   (cmd_asr),
        .cmd_steps (cmd_steps),
        .cmd_data  (cmd_data),
        .sr_q      (sr_q),
        .sr_shift  (sr_shift),
        .sr_right  (sr_right),
        .sr_asr    (sr_asr),
        .sr_data   (sr_data),
        .done      (done)
    );

    // Downstream load/rotate/ASR register: no enable, changes every edge.
    always @(posedge clk) begin
        if (sr_shift) begin
            if (sr_right) begin
                sr_q <= sr_asr ? {sr_q[7], sr_q[7:1]} : {sr_q[0], sr_q[7:1]};
            end else begin
                sr_q <= {sr_q[6:0], sr_q[7]};
            end
        end else begin
            sr_q <= sr_data;
        end
    end

    typedef struct {
        logic       ld;
        logic       rt;
        logic       asr;
        logic [3:0] steps;
        logic [7:0] data;
        logic [7:0] exp_q;
        int         exp_k;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_cmd(input vec_t v, input string nm);
        int   g;
        int   k;
        logic seen_asr;
        logic got;
        g = 0;
        @(negedge clk);
        while (!ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        cmd_load  = v.ld;
        cmd_right = v.rt;
        cmd_asr   = v.asr;
        cmd_steps = v.steps;
        cmd_data  = v.data;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cmd_load  = 1'($urandom);
        cmd_right = 1'($urandom);
        cmd_asr   = 1'($urandom);
        cmd_steps = 4'($urandom);
        cmd_data  = 8'($urandom);
        check({nm, " ready_low"}, 32'(ready), 32'd0);
        k = 0;
        seen_asr = sr_asr;
        got = done;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            seen_asr = seen_asr | sr_asr;
            got = done;
        end
        check({nm, " done_edge"}, 32'(k), 32'(v.exp_k));
        check({nm, " sr_q"}, 32'(sr_q), 32'(v.exp_q));
        check({nm, " asr_seen"}, 32'(seen_asr), 32'(v.asr & v.rt & (v.steps != 4'd0)));
    endtask

    initial begin
        logic [7:0] q_hold;
        logic       done_seen;

        //           ld    rt    asr   steps  data   exp_q  exp_k
        vt[0] = '{1'b1, 1'b1, 1'b0, 4'd3,  8'h81, 8'h30, 4};
        vt[1] = '{1'b1, 1'b1, 1'b1, 4'd2,  8'h80, 8'hE0, 3};
        vt[2] = '{1'b1, 1'b0, 1'b0, 4'd0,  8'h80, 8'h80, 1};
        vt[3] = '{1'b0, 1'b0, 1'b1, 4'd1,  8'h00, 8'h01, 1};
        vt[4] = '{1'b0, 1'b1, 1'b0, 4'd0,  8'hFF, 8'h01, 0};
        vt[5] = '{1'b1, 1'b0, 1'b0, 4'd8,  8'h5A, 8'h5A, 9};
        vt[6] = '{1'b1, 1'b1, 1'b1, 4'd15, 8'h80, 8'hFF, 16};
        vt[7] = '{1'b1, 1'b1, 1'b0, 4'd9,  8'h01, 8'h80, 10};
        vt[8] = '{1'b0, 1'b0, 1'b0, 4'd3,  8'h00, 8'h04, 3};

        #2;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst sr_shift", 32'(sr_shift), 32'd0);
        check("rst sr_right", 32'(sr_right), 32'd0);
        check("rst sr_asr", 32'(sr_asr), 32'd0);
        check("rst sr_data", 32'(sr_data), 32'(sr_q));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vt[i], $sformatf("vec%0d", i));
        end

        // Start asserted during DONE must be ignored.
        @(negedge clk);
        while (!ready) @(negedge clk);
        q_hold    = sr_q;
        cmd_load  = 1'b0;
        cmd_right = 1'b0;
        cmd_asr   = 1'b0;
        cmd_steps = 4'd0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        check("ign done", 32'(done), 32'd1);
        cmd_load  = 1'b1;
        cmd_data  = 8'hAA;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign ready", 32'(ready), 32'd1);
        check("ign no_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("ign sr_q", 32'(sr_q), 32'(q_hold));
        check("ign still_ready", 32'(ready), 32'd1);

        // Reset in the middle of a long shift.
        @(negedge clk);
        cmd_load  = 1'b1;
        cmd_right = 1'b1;
        cmd_asr   = 1'b0;
        cmd_steps = 4'd10;
        cmd_data  = 8'h81;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid sr_shift", 32'(sr_shift), 32'd1);
        reset = 1'b1;
        #1;
        check("mid rst ready", 32'(ready), 32'd1);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst sr_shift", 32'(sr_shift), 32'd0);
        q_hold = sr_q;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            done_seen = done_seen | done;
        end
        check("mid held sr_q", 32'(sr_q), 32'(q_hold));
        check("mid no_done", 32'(done_seen), 32'd0);

        run_cmd(vt[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rotator_sequencer.md
# rotator_sequencer

Control sequencer that sits directly upstream of the 8-bit load/rotate/arithmetic-shift register and drives its select, direction, ASR and parallel-data inputs. The register has no clock enable and changes every edge, so this block turns one accepted command into an exact cycle sequence: optional load, N shift steps, done. When idle it holds the register by reloading the register's own output.

## Interface
Parameters:
- WIDTH, 8, register width
- STEP_W, 4, width of step count (0..2^STEP_W-1 steps)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; async active-high reset
- start  in  1  command valid; accepted only when ready=1
- ready  out  1  high in IDLE only
- cmd_load  in  1  1 = parallel-load cmd_data before shifting
- cmd_right  in  1  1 = shift right, 0 = rotate left
- cmd_asr  in  1  1 = arithmetic right (MSB replicated); ignored when cmd_right=0
- cmd_steps  in  STEP_W  number of shift cycles
- cmd_data  in  WIDTH  load value
- sr_q  in  WIDTH  current register output (feedback for hold)
- sr_shift  out  1  1 = shift path, 0 = load path (drives register load-select)
- sr_right  out  1  direction to register
- sr_asr  out  1  ASR select to register
- sr_data  out  WIDTH  parallel data to register
- done  out  1  one-cycle pulse at end of command

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: ready=1, sr_shift=0, sr_data=sr_q (hold), sr_right=0, sr_asr=0. start=1 latches cmd_* into internal registers; next state LOAD if cmd_load, else SHIFT if cmd_steps!=0, else DONE.
- LOAD: sr_shift=0, sr_data=latched data; next SHIFT if steps!=0, else DONE.
- SHIFT: sr_shift=1, sr_right=latched right, sr_asr=latched asr AND latched right; step counter loaded with steps on acceptance, decrements each SHIFT cycle; leave to DONE when counter=1 (exactly N shift edges).
- DONE: done=1, hold as in IDLE, ready=0; next IDLE.
- start while ready=0 ignored; cmd_* changes after acceptance have no effect.
- Steps ≥ WIDTH allowed; no clamping (rotation wraps naturally, ASR saturates to all-sign).
- cmd_asr with cmd_right=0: plain left rotate.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, latched cmd=0; outputs immediately take IDLE values (ready=1, done=0, sr_shift=0, sr_data=sr_q). Reset mid-command abandons it; no done pulse.
- Acceptance edge E0. With load: register loads at E1, shifts at E2..E(N+1), done high during cycle after E(N+1), ready at E(N+2).
- Without load: shifts at E1..EN, done after EN, ready at E(N+1).
- N=0, no load: done in cycle after E0, ready at E1.
- Outputs are decoded from state and latched registers (Moore); sr_data in IDLE/DONE is combinational from sr_q.
- Back-to-back: start may be asserted in the cycle ready returns; accepted on that edge.

## Structure
- Shared package: state enum (IDLE, LOAD, SHIFT, DONE), state-width constant, default WIDTH/STEP_W.
- One sub-module natural: step_counter (load, decrement, last flag at 1).
- FSM, command latch and output decode in top.

## Test plan
- Reset: assert reset mid-SHIFT -> IDLE, ready=1, done=0 at once; register value held thereafter.
- Load+rotate right: data=8'b1000_0001, load=1, right=1, asr=0, steps=3 -> sr_q=0011_0000 when done pulses, done at E4.
- ASR: data=8'b1000_0000, load=1, right=1, asr=1, steps=2 -> sr_q=1110_0000.
- Left rotate, no load, asr=1 ignored: sr_q=1000_0000 held, steps=1 -> sr_q=0000_0001, sr_asr stays 0.
- Zero steps, no load: start -> done one cycle later, sr_q unchanged; start during DONE ignored.
- Wrap: data=8'h5A, load=1, right=0, steps=8 -> sr_q=8'h5A, done at E9.
